// File: rtl/square_game_ctrl_if.sv
// Game status bus between the square game sequencer and the VGA drawing path.
// The sequencer drives every field from registers; the drawing path only reads.
//   player_center_x/y : player box centre (pixels)
//   target_center_x/y : target box centre (pixels)
//   score             : captures this game, saturating at 16'hFFFF
//   frames_left       : frames remaining in the current game
//   game_state        : 0 IDLE, 1 PLAY, 2 HIT, 3 OVER
//   hit               : one-cycle pulse on a capture
interface square_game_ctrl_if;
    logic [9:0]  player_center_x;
    logic [9:0]  player_center_y;
    logic [9:0]  target_center_x;
    logic [9:0]  target_center_y;
    logic [15:0] score;
    logic [10:0] frames_left;
    logic [1:0]  game_state;
    logic        hit;

    modport master (
        output player_center_x, player_center_y,
        output target_center_x, target_center_y,
        output score, frames_left, game_state, hit
    );

    modport slave (
        input player_center_x, player_center_y,
        input target_center_x, target_center_y,
        input score, frames_left, game_state, hit
    );
endinterface

// File: rtl/square_game_ctrl.sv
// Per-frame game sequencer for the square game.
// Owns player/target centres, frame timer, score and game state. State only
// advances on the frame-boundary pulse (screenEnd), so sprites never move
// mid-frame; the capture check runs every cycle while playing.
// Ports:
//   clk_25mHz              : pixel clock, all logic on rising edge
//   reset                  : asynchronous, active-low
//   screenEnd              : one-cycle pulse between frames
//   btn_start              : start/restart level, rising edge used
//   BTNU/BTND/BTNL/BTNR    : synchronous move buttons
//   game                   : registered status bus (master side)
module square_game_ctrl #(
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter int          PLAYER_HALF = 25,
    parameter int          TARGET_HALF = 30,
    parameter int          STEP        = 4,
    parameter int          GAME_FRAMES = 1800,
    parameter int          HIT_FRAMES  = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk_25mHz,
    input  logic reset,
    input  logic screenEnd,
    input  logic btn_start,
    input  logic BTNU,
    input  logic BTND,
    input  logic BTNL,
    input  logic BTNR,
    square_game_ctrl_if.master game
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

    localparam logic signed [10:0] X_MIN       = 11'(PLAYER_HALF);
    localparam logic signed [10:0] X_MAX       = 11'(SCREEN_W - 1 - PLAYER_HALF);
    localparam logic signed [10:0] Y_MIN       = 11'(PLAYER_HALF);
    localparam logic signed [10:0] Y_MAX       = 11'(SCREEN_H - 1 - PLAYER_HALF);
    localparam logic signed [10:0] STEP_S      = 11'(STEP);
    localparam logic [9:0]         REACH       = 10'(PLAYER_HALF + TARGET_HALF);
    localparam logic [9:0]         TOFF        = 10'(TARGET_HALF);
    localparam logic [10:0]        FRAMES_INIT = 11'(GAME_FRAMES);
    localparam int                 HCW         = $clog2(HIT_FRAMES + 1);
    localparam logic [HCW-1:0]     HIT_LAST    = HCW'(HIT_FRAMES);
    localparam logic [9:0]         PX0 = 10'd480, PY0 = 10'd360, TX0 = 10'd160, TY0 = 10'd120;

    // One axis step in 11-bit signed arithmetic, clamped so the box never wraps.
    function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic signed [10:0] lo,
                                             input logic signed [10:0] hi);
        logic signed [10:0] delta;
        logic signed [10:0] sum;
        if (dec && !inc)      delta = -STEP_S;
        else if (inc && !dec) delta = STEP_S;
        else                  delta = 11'sd0;
        sum = $signed({1'b0, pos}) + delta;
        if (sum < lo)      sum = lo;
        else if (sum > hi) sum = hi;
        else               sum = sum;
        return sum[9:0];
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Fold the 0..1023 LFSR slice into 0..579 so the target stays on screen.
    function automatic logic [9:0] reloc_x(input logic [15:0] l);
        logic [9:0] c;
        c = l[9:0];
        if (c >= 10'd580) c = c - 10'd512;
        else              c = c;
        return TOFF + c;
    endfunction

    // Fold the 0..511 LFSR slice into 0..419.
    function automatic logic [9:0] reloc_y(input logic [15:0] l);
        logic [8:0] c;
        c = l[15:7];
        if (c >= 9'd420) c = c - 9'd256;
        else             c = c;
        return TOFF + {1'b0, c};
    endfunction

    state_t         state_r, state_s;
    logic [9:0]     px_r, px_s, py_r, py_s, tx_r, tx_s, ty_r, ty_s;
    logic [15:0]    score_r, score_s;
    logic [10:0]    fl_r, fl_s;
    logic           hit_r, hit_s;
    logic [HCW-1:0] hcnt_r, hcnt_s, hcnt_inc_s;
    logic [15:0]    lfsr_r, lfsr_s;
    logic           start_q_r;
    logic           start_edge_s, overlap_s;

    assign start_edge_s = btn_start & ~start_q_r;
    assign hcnt_inc_s   = hcnt_r + HCW'(1);
    assign overlap_s    = (abs_diff(px_r, tx_r) < REACH) && (abs_diff(py_r, ty_r) < REACH);

    // Next-state and next-value logic for the whole game.
    always_comb begin
        state_s = state_r;
        px_s    = px_r;
        py_s    = py_r;
        tx_s    = tx_r;
        ty_s    = ty_r;
        score_s = score_r;
        fl_s    = fl_r;
        hit_s   = 1'b0;
        hcnt_s  = hcnt_r;
        lfsr_s  = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        case (state_r)
            IDLE, OVER: begin
                if (start_edge_s) begin
                    score_s = 16'd0;
                    fl_s    = FRAMES_INIT;
                    px_s    = PX0;
                    py_s    = PY0;
                    tx_s    = TX0;
                    ty_s    = TY0;
                    hcnt_s  = '0;
                    state_s = PLAY;
                end else begin
                    state_s = state_r;
                end
            end
            PLAY, HIT: begin
                if ((state_r == PLAY) && overlap_s) begin
                    hit_s   = 1'b1;
                    score_s = (score_r == 16'hFFFF) ? score_r : (score_r + 16'd1);
                    tx_s    = reloc_x(lfsr_r);
                    ty_s    = reloc_y(lfsr_r);
                    hcnt_s  = '0;
                    state_s = HIT;
                end else begin
                    hit_s = 1'b0;
                end
                if (screenEnd) begin
                    px_s = move_axis(px_r, BTNL, BTNR, X_MIN, X_MAX);
                    py_s = move_axis(py_r, BTNU, BTND, Y_MIN, Y_MAX);
                    fl_s = fl_r - 11'd1;
                    // Timer expiry wins over both the HIT exit and any capture.
                    if (fl_r == 11'd1) begin
                        state_s = OVER;
                    end else if (state_r == HIT) begin
                        if (hcnt_inc_s == HIT_LAST) begin
                            state_s = PLAY;
                            hcnt_s  = '0;
                        end else begin
                            hcnt_s = hcnt_inc_s;
                        end
                    end else begin
                        state_s = state_s;
                    end
                end else begin
                    fl_s = fl_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            px_r      <= PX0;
            py_r      <= PY0;
            tx_r      <= TX0;
            ty_r      <= TY0;
            score_r   <= 16'd0;
            fl_r      <= FRAMES_INIT;
            hit_r     <= 1'b0;
            hcnt_r    <= '0;
            lfsr_r    <= LFSR_SEED;
            start_q_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            px_r      <= px_s;
            py_r      <= py_s;
            tx_r      <= tx_s;
            ty_r      <= ty_s;
            score_r   <= score_s;
            fl_r      <= fl_s;
            hit_r     <= hit_s;
            hcnt_r    <= hcnt_s;
            lfsr_r    <= lfsr_s;
            start_q_r <= btn_start;
        end
    end

    assign game.player_center_x = px_r;
    assign game.player_center_y = py_r;
    assign game.target_center_x = tx_r;
    assign game.target_center_y = ty_r;
    assign game.score           = score_r;
    assign game.frames_left     = fl_r;
    assign game.game_state      = state_r;
    assign game.hit             = hit_r;
endmodule

// File: tb/tb_square_game_ctrl.sv
// Self-checking bench for square_game_ctrl. A default instance plays full
// games; a second instance with a 5-frame game and 64-pixel step covers
// timer expiry and start-button edge handling.
module tb_square_game_ctrl;
    logic clk_25mHz = 1'b0;
    logic reset, reset5, screenEnd, screenEnd5, btn_start, btn_start5;
    logic BTNU, BTND, BTNL, BTNR;
    int   checks = 0;
    int   errors = 0;

    square_game_ctrl_if bus ();
    square_game_ctrl_if bus5 ();

    always #5 clk_25mHz = ~clk_25mHz;

    square_game_ctrl dut (
        .clk_25mHz(clk_25mHz), .reset(reset), .screenEnd(screenEnd), .btn_start(btn_start),
        .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .game(bus)
    );

    square_game_ctrl #(.GAME_FRAMES(5), .STEP(64)) dut5 (
        .clk_25mHz(clk_25mHz), .reset(reset5), .screenEnd(screenEnd5), .btn_start(btn_start5),
        .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .game(bus5)
    );

    // Reference LFSR
    logic [15:0] lfsr_m;
    always @(posedge clk_25mHz or negedge reset) begin
        if (!reset) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct { int px; int py; int fl; } frame_t;
    typedef struct { int tx; int ty; } tgt_t;
    frame_t frame_q[$];
    tgt_t   hit_q[$];
    int m_px, m_py, m_tx, m_ty, m_fl, m_score;

    // Called at a negedge; one screenEnd on the default instance.
    task automatic do_frame(input logic l, input logic r, input logic u, input logic d);
        frame_t e;
        BTNL = l; BTNR = r; BTNU = u; BTND = d;
        if (l && !r) m_px = m_px - 4; else if (r && !l) m_px = m_px + 4;
        if (u && !d) m_py = m_py - 4; else if (d && !u) m_py = m_py + 4;
        if (m_px < 25) m_px = 25; if (m_px > 614) m_px = 614;
        if (m_py < 25) m_py = 25; if (m_py > 454) m_py = 454;
        m_fl = m_fl - 1;
        e.px = m_px; e.py = m_py; e.fl = m_fl;
        frame_q.push_back(e);
        screenEnd = 1'b1;
        @(negedge clk_25mHz);
        screenEnd = 1'b0; BTNL = 1'b0; BTNR = 1'b0; BTNU = 1'b0; BTND = 1'b0;
        e = frame_q.pop_front();
        checks++;
        if (bus.player_center_x !== 10'(e.px)) begin errors++; $display("FAIL frame_px: got %0d expected %0d", bus.player_center_x, e.px); end
        checks++;
        if (bus.player_center_y !== 10'(e.py)) begin errors++; $display("FAIL frame_py: got %0d expected %0d", bus.player_center_y, e.py); end
        checks++;
        if (bus.frames_left !== 11'(e.fl)) begin errors++; $display("FAIL frame_fl: got %0d expected %0d", bus.frames_left, e.fl); end
    endtask

    task automatic test_reset();
        reset = 1'b0; reset5 = 1'b0; screenEnd = 1'b0; screenEnd5 = 1'b0;
        btn_start = 1'b0; btn_start5 = 1'b0; BTNU = 1'b0; BTND = 1'b0; BTNL = 1'b0; BTNR = 1'b0;
        repeat (3) @(negedge clk_25mHz);
        checks++; if (bus.game_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", bus.game_state); end
        checks++; if (bus.player_center_x !== 10'd480 || bus.player_center_y !== 10'd360) begin errors++; $display("FAIL rst_player: got %0d,%0d expected 480,360", bus.player_center_x, bus.player_center_y); end
        checks++; if (bus.target_center_x !== 10'd160 || bus.target_center_y !== 10'd120) begin errors++; $display("FAIL rst_target: got %0d,%0d expected 160,120", bus.target_center_x, bus.target_center_y); end
        checks++; if (bus.score !== 16'd0 || bus.hit !== 1'b0) begin errors++; $display("FAIL rst_score_hit: got %0d,%0b expected 0,0", bus.score, bus.hit); end
        checks++; if (bus.frames_left !== 11'd1800) begin errors++; $display("FAIL rst_frames: got %0d expected 1800", bus.frames_left); end
        reset = 1'b1;
        @(negedge clk_25mHz);
        // screenEnd in IDLE is ignored
        BTNR = 1'b1; screenEnd = 1'b1;
        @(negedge clk_25mHz);
        BTNR = 1'b0; screenEnd = 1'b0;
        checks++; if (bus.game_state !== 2'd0 || bus.player_center_x !== 10'd480 || bus.frames_left !== 11'd1800) begin
            errors++; $display("FAIL idle_ignore: got state %0d x %0d fl %0d expected 0 480 1800", bus.game_state, bus.player_center_x, bus.frames_left); end
    endtask

    task automatic test_move_right();
        btn_start = 1'b1;
        @(negedge clk_25mHz);
        btn_start = 1'b0;
        checks++; if (bus.game_state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", bus.game_state); end
        m_px = 480; m_py = 360; m_tx = 160; m_ty = 120; m_fl = 1800; m_score = 0;
        for (int i = 0; i < 40; i++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.player_center_x !== 10'd614 || bus.player_center_y !== 10'd360 || bus.frames_left !== 11'd1760) begin
            errors++; $display("FAIL right_end: got %0d,%0d fl %0d expected 614,360 fl 1760", bus.player_center_x, bus.player_center_y, bus.frames_left); end
        // start edge ignored while playing
        btn_start = 1'b1;
        @(negedge clk_25mHz);
        btn_start = 1'b0;
        @(negedge clk_25mHz);
        checks++; if (bus.game_state !== 2'd1 || bus.frames_left !== 11'd1760) begin
            errors++; $display("FAIL start_in_play: got state %0d fl %0d expected 1 1760", bus.game_state, bus.frames_left); end
    endtask

    task automatic test_both_then_up();
        for (int i = 0; i < 10; i++) do_frame(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.player_center_x !== 10'd614 || bus.player_center_y !== 10'd360) begin
            errors++; $display("FAIL both_lr: got %0d,%0d expected 614,360", bus.player_center_x, bus.player_center_y); end
        for (int i = 0; i < 100; i++) do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.player_center_y !== 10'd25 || bus.frames_left !== 11'd1650) begin
            errors++; $display("FAIL up_clamp: got y %0d fl %0d expected 25 1650", bus.player_center_y, bus.frames_left); end
    endtask

    // Called at a negedge with the player overlapping the target in PLAY.
    task automatic expect_hit();
        tgt_t t;
        logic [9:0] cx;
        logic [8:0] cy;
        cx = lfsr_m[9:0];
        if (cx >= 10'd580) cx = cx - 10'd512;
        cy = lfsr_m[15:7];
        if (cy >= 9'd420) cy = cy - 9'd256;
        t.tx = 30 + int'(cx); t.ty = 30 + int'(cy);
        hit_q.push_back(t);
        @(negedge clk_25mHz);
        t = hit_q.pop_front();
        m_score++; m_tx = t.tx; m_ty = t.ty;
        checks++; if (bus.hit !== 1'b1 || bus.game_state !== 2'd2) begin errors++; $display("FAIL hit_pulse: got hit %0b state %0d expected 1 2", bus.hit, bus.game_state); end
        checks++; if (bus.score !== 16'(m_score)) begin errors++; $display("FAIL hit_score: got %0d expected %0d", bus.score, m_score); end
        checks++; if (bus.target_center_x !== 10'(t.tx) || bus.target_center_y !== 10'(t.ty)) begin
            errors++; $display("FAIL hit_target: got %0d,%0d expected %0d,%0d", bus.target_center_x, bus.target_center_y, t.tx, t.ty); end
        checks++; if (bus.target_center_x < 10'd30 || bus.target_center_x > 10'd609 || bus.target_center_y < 10'd30 || bus.target_center_y > 10'd449) begin
            errors++; $display("FAIL hit_range: got %0d,%0d expected inside [30,609]x[30,449]", bus.target_center_x, bus.target_center_y); end
        @(negedge clk_25mHz);
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL hit_one_cycle: got %0b expected 0", bus.hit); end
    endtask

    task automatic chase();
        int  n;
        bit  ov;
        n = 0;
        ov = ((m_px > m_tx ? m_px - m_tx : m_tx - m_px) < 55) && ((m_py > m_ty ? m_py - m_ty : m_ty - m_py) < 55);
        while (!ov && n < 400) begin
            do_frame(m_px - m_tx >= 55, m_tx - m_px >= 55, m_py - m_ty >= 55, m_ty - m_py >= 55);
            checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL early_hit: got 1 expected 0"); end
            n++;
            ov = ((m_px > m_tx ? m_px - m_tx : m_tx - m_px) < 55) && ((m_py > m_ty ? m_py - m_ty : m_ty - m_py) < 55);
        end
        if (!ov) begin checks++; errors++; $display("FAIL chase_timeout: got no overlap expected overlap"); end
        else expect_hit();
    endtask

    task automatic hold_hit();
        for (int i = 1; i <= 30; i++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.game_state !== ((i == 30) ? 2'd1 : 2'd2)) begin
                errors++; $display("FAIL hit_hold_%0d: got %0d expected %0d", i, bus.game_state, (i == 30) ? 1 : 2); end
        end
    endtask

    task automatic test_capture();
        for (int k = 0; k < 3; k++) begin
            chase();
            hold_hit();
        end
    endtask

    task automatic test_reset_mid();
        checks++; if (bus.score !== 16'd3 || bus.game_state !== 2'd1) begin errors++; $display("FAIL pre_reset: got score %0d state %0d expected 3 1", bus.score, bus.game_state); end
        reset = 1'b0;
        #1;
        checks++; if (bus.score !== 16'd0 || bus.game_state !== 2'd0 || bus.frames_left !== 11'd1800 || bus.hit !== 1'b0) begin
            errors++; $display("FAIL async_reset: got score %0d state %0d fl %0d hit %0b expected 0 0 1800 0", bus.score, bus.game_state, bus.frames_left, bus.hit); end
        checks++; if (bus.player_center_x !== 10'd480 || bus.player_center_y !== 10'd360 || bus.target_center_x !== 10'd160 || bus.target_center_y !== 10'd120) begin
            errors++; $display("FAIL async_reset_pos: got %0d,%0d %0d,%0d expected 480,360 160,120", bus.player_center_x, bus.player_center_y, bus.target_center_x, bus.target_center_y); end
        repeat (2) @(negedge clk_25mHz);
        reset = 1'b1;
        repeat (2) @(negedge clk_25mHz);
        checks++; if (bus.game_state !== 2'd0 || bus.player_center_x !== 10'd480) begin errors++; $display("FAIL post_reset: got state %0d x %0d expected 0 480", bus.game_state, bus.player_center_x); end
    endtask

    task automatic frame5(input logic l, input logic u);
        BTNL = l; BTNU = u; screenEnd5 = 1'b1;
        @(negedge clk_25mHz);
        BTNL = 1'b0; BTNU = 1'b0; screenEnd5 = 1'b0;
    endtask

    task automatic test_over();
        reset5 = 1'b1;
        @(negedge clk_25mHz);
        btn_start5 = 1'b1;
        @(negedge clk_25mHz);
        checks++; if (bus5.game_state !== 2'd1 || bus5.frames_left !== 11'd5) begin errors++; $display("FAIL over_start: got state %0d fl %0d expected 1 5", bus5.game_state, bus5.frames_left); end
        for (int i = 1; i <= 4; i++) begin
            frame5(1'b1, 1'b1);
            checks++; if (bus5.frames_left !== 11'(5 - i) || bus5.game_state !== 2'd1) begin
                errors++; $display("FAIL over_frame_%0d: got fl %0d state %0d expected %0d 1", i, bus5.frames_left, bus5.game_state, 5 - i); end
        end
        frame5(1'b1, 1'b0);
        checks++; if (bus5.player_center_x !== 10'd160 || bus5.player_center_y !== 10'd104 || bus5.frames_left !== 11'd0 || bus5.game_state !== 2'd3) begin
            errors++; $display("FAIL over_last: got %0d,%0d fl %0d state %0d expected 160,104 0 3", bus5.player_center_x, bus5.player_center_y, bus5.frames_left, bus5.game_state); end
        @(negedge clk_25mHz);
        checks++; if (bus5.hit !== 1'b0 || bus5.score !== 16'd0 || bus5.game_state !== 2'd3) begin
            errors++; $display("FAIL over_no_hit: got hit %0b score %0d state %0d expected 0 0 3", bus5.hit, bus5.score, bus5.game_state); end
        BTNR = 1'b1;
        frame5(1'b0, 1'b0);
        BTNR = 1'b0;
        checks++; if (bus5.player_center_x !== 10'd160 || bus5.frames_left !== 11'd0 || bus5.game_state !== 2'd3) begin
            errors++; $display("FAIL over_frozen: got x %0d fl %0d state %0d expected 160 0 3", bus5.player_center_x, bus5.frames_left, bus5.game_state); end
    endtask

    task automatic test_start_hold();
        repeat (3) @(negedge clk_25mHz);
        checks++; if (bus5.game_state !== 2'd3) begin errors++; $display("FAIL held_no_restart: got %0d expected 3", bus5.game_state); end
        btn_start5 = 1'b0;
        @(negedge clk_25mHz);
        checks++; if (bus5.game_state !== 2'd3) begin errors++; $display("FAIL release_no_restart: got %0d expected 3", bus5.game_state); end
        btn_start5 = 1'b1;
        @(negedge clk_25mHz);
        checks++; if (bus5.game_state !== 2'd1 || bus5.score !== 16'd0 || bus5.frames_left !== 11'd5) begin
            errors++; $display("FAIL restart: got state %0d score %0d fl %0d expected 1 0 5", bus5.game_state, bus5.score, bus5.frames_left); end
        checks++; if (bus5.player_center_x !== 10'd480 || bus5.player_center_y !== 10'd360) begin
            errors++; $display("FAIL restart_pos: got %0d,%0d expected 480,360", bus5.player_center_x, bus5.player_center_y); end
        btn_start5 = 1'b0;
    endtask

    initial begin
        @(negedge clk_25mHz);
        test_reset();
        test_move_right();
        test_both_then_up();
        test_capture();
        test_reset_mid();
        test_over();
        test_start_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
